// File: rtl/led_flow_sequencer_if.sv
// Pushbutton/switch inputs and decoder-facing outputs of the LED flow sequencer.
// The sequencer uses the slave side; the board/top level or bench uses the master side.
interface led_flow_sequencer_if;
    logic key_dir;
    logic key_pause;
    logic mode_bounce;
    logic a;
    logic b;
    logic c;
    logic step;
    logic dir;
    logic running;

    modport master (
        output key_dir, key_pause, mode_bounce,
        input  a, b, c, step, dir, running
    );

    modport slave (
        input  key_dir, key_pause, mode_bounce,
        output a, b, c, step, dir, running
    );
endinterface

// File: rtl/led_flow_sequencer.sv
// Steps a single lit LED across 8 positions (wrap or bounce) at a prescaled rate,
// with debounced direction and pause pushbuttons.
module led_flow_sequencer #(
    parameter int CNT_MAX = 24_999_999,
    parameter int DEB_MAX = 999_999
) (
    input logic clk,
    input logic rst,
    led_flow_sequencer_if.slave bus
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int DEB_W = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic [DEB_W-1:0] DEB_TOP = DEB_W'(DEB_MAX);

    // Key index 0 is the direction button, index 1 is the pause button.
    logic [1:0]            key_s1;
    logic [1:0]            key_s2;
    logic [1:0]            key_deb;
    logic [1:0]            key_press;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic                  mode_s1;
    logic                  mode_s2;

    logic [CNT_W-1:0] pre_cnt;
    logic             step_now;
    logic [2:0]       idx;
    logic [2:0]       idx_next;
    logic             dir_q;
    logic             dir_after_key;
    logic             dir_next;
    logic             running_q;
    logic             step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1  <= '0;
            key_s2  <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            key_s1  <= {bus.key_pause, bus.key_dir};
            key_s2  <= key_s1;
            mode_s1 <= bus.mode_bounce;
            mode_s2 <= mode_s1;
        end
    end

    // A differing level must persist DEB_MAX+1 clocks before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_deb <= '0;
            deb_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k] == key_deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_TOP) begin
                    key_deb[k] <= key_s2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        key_press = '0;
        for (int k = 0; k < 2; k++) begin
            key_press[k] = key_s2[k] && !key_deb[k] && (deb_cnt[k] == DEB_TOP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (running_q) begin
            pre_cnt <= (pre_cnt == CNT_TOP) ? '0 : pre_cnt + CNT_W'(1);
        end
    end

    assign step_now = running_q && (pre_cnt == CNT_TOP);

    // A same-cycle dir press is applied before bounce reversal is evaluated.
    always_comb begin
        dir_after_key = dir_q ^ key_press[0];
        dir_next      = dir_after_key;
        idx_next      = idx;
        if (step_now) begin
            if (mode_s2 && !dir_after_key && (idx == 3'd7)) begin
                dir_next = 1'b1;
                idx_next = 3'd6;
            end else if (mode_s2 && dir_after_key && (idx == 3'd0)) begin
                dir_next = 1'b0;
                idx_next = 3'd1;
            end else if (dir_after_key) begin
                idx_next = idx - 3'd1;
            end else begin
                idx_next = idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 3'd0;
            dir_q     <= 1'b0;
            running_q <= 1'b1;
            step_q    <= 1'b0;
        end else begin
            idx       <= idx_next;
            dir_q     <= dir_next;
            running_q <= running_q ^ key_press[1];
            step_q    <= step_now;
        end
    end

    assign bus.a       = idx[2];
    assign bus.b       = idx[1];
    assign bus.c       = idx[0];
    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_led_flow_sequencer.sv
// Randomized bench for led_flow_sequencer with small prescale/debounce counts,
// compared every clock against a behavioural position/debounce model.
module tb_led_flow_sequencer;

    localparam int CNT_MAX = 3;
    localparam int DEB_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    led_flow_sequencer_if bus();

    led_flow_sequencer #(.CNT_MAX(CNT_MAX), .DEB_MAX(DEB_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount   = 0;
    logic modeSw    = 1'b0;

    // Model state: LED position, direction, run flag, clocks into current step period,
    // two-stage input delay (keys + mode), accepted key levels and their disagreement run lengths.
    int       mPos;
    logic     mDir;
    logic     mRun;
    int       mTicks;
    logic     mStep;
    logic [2:0] dly0;
    logic [2:0] dly1;
    logic [1:0] mStable;
    int       mRunLen [2];

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic kd, input logic kp, input logic mb);
        logic [2:0] lvl;
        logic [1:0] press;
        if (r) begin
            mPos = 0; mDir = 1'b0; mRun = 1'b1; mTicks = 0; mStep = 1'b0;
            dly0 = '0; dly1 = '0; mStable = '0; mRunLen[0] = 0; mRunLen[1] = 0;
            return;
        end
        lvl   = dly1;
        dly1  = dly0;
        dly0  = {mb, kp, kd};
        press = '0;
        for (int k = 0; k < 2; k++) begin
            if (lvl[k] == mStable[k]) begin
                mRunLen[k] = 0;
            end else begin
                mRunLen[k]++;
                if (mRunLen[k] == DEB_MAX + 1) begin
                    mStable[k] = lvl[k];
                    mRunLen[k] = 0;
                    press[k]   = lvl[k];
                end
            end
        end
        mDir  = mDir ^ press[0];
        mStep = 1'b0;
        if (mRun) begin
            mTicks++;
            if (mTicks == CNT_MAX + 1) begin
                mTicks = 0;
                mStep  = 1'b1;
            end
        end
        if (mStep) begin
            if (!lvl[2]) begin
                mPos = mDir ? (mPos + 7) % 8 : (mPos + 1) % 8;
            end else if (!mDir) begin
                if (mPos == 7) begin mDir = 1'b1; mPos = 6; end
                else mPos = mPos + 1;
            end else begin
                if (mPos == 0) begin mDir = 1'b0; mPos = 1; end
                else mPos = mPos - 1;
            end
        end
        mRun = mRun ^ press[1];
    endtask

    task automatic applyStimulus(input logic r, input logic kd, input logic kp, input logic mb);
        rst             = r;
        bus.key_dir     = kd;
        bus.key_pause   = kp;
        bus.mode_bounce = mb;
        @(posedge clk);
        modelStep(r, kd, kp, mb);
        #1;
        checkOutput("idx", {5'b0, bus.a, bus.b, bus.c}, 8'(mPos));
        checkOutput("step", {7'b0, bus.step}, {7'b0, mStep});
        checkOutput("dir", {7'b0, bus.dir}, {7'b0, mDir});
        checkOutput("running", {7'b0, bus.running}, {7'b0, mRun});
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, modeSw);
    endtask

    task automatic holdKeys(input logic kd, input logic kp, input int n);
        repeat (n) applyStimulus(1'b0, kd, kp, modeSw);
        applyStimulus(1'b0, 1'b0, 1'b0, modeSw);
    endtask

    initial begin
        int   found;
        int   kind;
        int   len;
        logic kdR;
        logic kpR;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] wrap sweep");
        idle(36);
        $display("[TB] bounce sweep");
        modeSw = 1'b1;
        idle(70);
        modeSw = 1'b0;
        idle(10);

        $display("[TB] dir key glitch then long press");
        holdKeys(1'b1, 1'b0, 3);
        idle(10);
        holdKeys(1'b1, 1'b0, 8);
        idle(40);

        $display("[TB] pause and resume");
        holdKeys(1'b0, 1'b1, 8);
        idle(40);
        holdKeys(1'b0, 1'b1, 8);
        idle(10);

        $display("[TB] reset while paused and mid-debounce");
        holdKeys(1'b1, 1'b0, 8);
        holdKeys(1'b0, 1'b1, 8);
        idle(12);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, modeSw);
        applyStimulus(1'b1, 1'b0, 1'b0, modeSw);
        idle(20);

        $display("[TB] dir press coinciding with bounce reversal");
        modeSw = 1'b1;
        idle(4);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (mPos == 6 && !mDir && mTicks == 1 && mRun && dly0 == 3'b100 && dly1 == 3'b100
                && mStable == 2'b00 && mRunLen[0] == 0)
                found = 1;
            else
                idle(1);
        end
        checkOutput("align_found", 8'(found), 8'd1);
        if (found != 0) begin
            holdKeys(1'b1, 1'b0, 8);
            idle(12);
        end

        $display("[TB] randomized segments");
        for (int s = 0; s < 120; s++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: idle($urandom_range(3, 30));
                4: holdKeys(1'b1, 1'b0, $urandom_range(1, 12));
                5: holdKeys(1'b0, 1'b1, $urandom_range(1, 12));
                6: holdKeys(1'b1, 1'b1, $urandom_range(1, 12));
                7: begin modeSw = ~modeSw; idle($urandom_range(1, 10)); end
                8: applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), modeSw);
                default: begin
                    len = $urandom_range(5, 15);
                    for (int i = 0; i < len; i++) begin
                        kdR = 1'($urandom_range(0, 1));
                        kpR = 1'($urandom_range(0, 1));
                        applyStimulus(1'b0, kdR, kpR, modeSw);
                    end
                end
            endcase
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/led_flow_sequencer.md
Name: led_flow_sequencer

Overview:
- Upstream driver for the 3-to-8 one-hot LED decoder. Produces the 3-bit select `{a,b,c}` that steps a single lit LED across 8 positions at a programmable rate.
- Supports wrap and bounce patterns, a direction toggle and pause/resume.
- The two control pushbuttons are synchronised and debounced inside the block.
- Sits between board pushbuttons/switch and the decoder in the LED flow-light top level.

Parameters:
- CNT_MAX, 24_999_999, prescaler terminal count. Step period = CNT_MAX+1 clocks (0.5 s at 50 MHz).
- DEB_MAX, 999_999, debounce terminal count. A key level must be stable for DEB_MAX+1 clocks (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_dir  input  1  raw pushbutton, active-high, asynchronous to clk; a debounced press toggles direction.
- key_pause  input  1  raw pushbutton, active-high, asynchronous; a debounced press toggles run/pause.
- mode_bounce  input  1  static switch, synchronised internally: 0 = wrap, 1 = bounce.
- a  output  1  select bit 2 (MSB) to decoder.
- b  output  1  select bit 1.
- c  output  1  select bit 0 (LSB).
- step  output  1  one-clock pulse, high in the cycle the index updates.
- dir  output  1  current direction: 0 = up (index increasing), 1 = down.
- running  output  1  1 = stepping, 0 = paused.

Behaviour:
- Reset (rst=1 at a clk edge) produces:
  - idx=0, so {a,b,c}=3'b000; step=0; dir=0; running=1.
  - Prescaler=0, debounce counters=0, synchroniser and debounced states=0.
  - mode_bounce synchroniser flops reset to 0.
  - Reset mid-step or mid-debounce aborts everything; no step pulse or toggle is emitted in the cycle after reset.
- Synchronisers: 2-flop for each key and for mode_bounce. Effective latency is 2 clocks.
- Debounce, per key:
  - The counter clears whenever the synchronised level equals the debounced state.
  - Otherwise it increments. When it reaches DEB_MAX, the debounced state takes the new level and the counter clears.
  - A press event is a one-clock pulse on the debounced 0->1 transition only. Release produces no event.
  - Glitches shorter than DEB_MAX+1 clocks produce no event.
- Toggles:
  - A dir press event flips dir.
  - A pause press event flips running.
  - Both events in the same cycle: both flip.
- Prescaler:
  - Increments only while running=1. While paused it holds its value; it is not cleared.
  - At CNT_MAX it wraps to 0 and raises step for that one cycle.
- Index update on step, using dir as it will be after any same-cycle dir toggle:
  - Wrap mode, dir=0: idx+1 modulo 8 (7 -> 0).
  - Wrap mode, dir=1: idx-1 modulo 8 (0 -> 7).
  - Bounce mode, dir=0 and idx=7: dir <= 1, idx <= 6. Otherwise idx+1.
  - Bounce mode, dir=1 and idx=0: dir <= 0, idx <= 1. Otherwise idx-1.
  - Bounce reversal and a same-cycle dir press: the press is applied first. Reversal is then evaluated on the resulting dir, so the index never leaves 0..7.
- Pause press in the same cycle as a step:
  - The step still takes effect.
  - running flips afterwards; the prescaler is at 0 after that step.
- Mode change takes effect at the next step. No immediate index change.
- Outputs:
  - a, b, c, step, dir and running are registered; no combinational path from inputs.
  - idx drives {a,b,c} directly: a=idx[2], c=idx[0].
- Widths:
  - Prescaler is ceil(log2(CNT_MAX+1)) bits.
  - Debounce counters are ceil(log2(DEB_MAX+1)) bits.
  - No overflow past the terminal count.

Test Plan (CNT_MAX=3, DEB_MAX=4):
1. Reset then idle, mode_bounce=0:
   - step pulses every 4 clocks.
   - {a,b,c} sequence 0,1,...,7,0.
   - dir=0, running=1 throughout.
2. mode_bounce=1, run 16 steps:
   - Index sequence 1..7,6,5,...,0,1,2.
   - dir goes to 1 in the step that produces 6, and back to 0 in the step that produces 1.
3. key_dir pulse 3 clocks wide:
   - No toggle.
   - Hold key_dir high 8 clocks: dir flips exactly once, 7 clocks after the rising edge (2 sync + 5 debounce).
   - Then in wrap mode, 0 steps to 7.
4. key_pause press while idx=3:
   - running=0; no step pulses for 40 clocks; idx holds 3.
   - Second press resumes; the first step arrives within 4 clocks with idx=4.
5. Assert rst for 1 cycle at idx=5, dir=1, paused, mid-debounce:
   - Next cycle: idx=0, dir=0, running=1, step=0.
   - The pending key press is discarded.
6. Bounce mode at idx=7 with dir=0: dir press event in the same cycle as step:
   - dir becomes 1 from the toggle, so idx=6 and dir=1.
   - Also check a dir press while idx=0 and dir=1 in wrap mode: next step gives idx=1.
